// File: rtl/return_addr_stack.sv
// Return-address stack for the fetch path: calls push the link address, and returns pop it
// to predict the jump target. Storage is circular and the oldest entry is overwritten on overflow.
module return_addr_stack #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_addr,
    input  logic        pop,
    output logic [31:0] top_addr,
    output logic        top_valid,
    output logic        full,
    output logic        empty,
    output logic        underflow,
    output logic        overflow
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W + 1)'(1'b0);
    localparam logic [PTR_W-1:0] TP_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] TP_ZERO = PTR_W'(1'b0);

    logic [29:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] tp_r;
    logic [PTR_W:0]   count_r;
    logic             underflow_r;
    logic             overflow_r;

    logic [PTR_W-1:0] tp_nxt_s;
    logic [PTR_W-1:0] wr_idx_s;
    logic [PTR_W-1:0] top_idx_s;
    logic [PTR_W:0]   count_nxt_s;
    logic             wr_en_s;
    logic             uf_nxt_s;
    logic             of_nxt_s;
    logic             empty_s;
    logic             full_s;
    logic             unused_addr_s;

    // Link addresses are word aligned, so the two low bits carry no information.
    assign unused_addr_s = ^push_addr[1:0];

    assign empty_s   = (count_r == CNT_ZERO);
    assign full_s    = (count_r == DEPTH_C);
    assign top_idx_s = tp_r - TP_ONE;

    // Next-state decode: flush wins, then the push/pop combination.
    always_comb begin
        tp_nxt_s    = tp_r;
        count_nxt_s = count_r;
        wr_en_s     = 1'b0;
        wr_idx_s    = tp_r;
        uf_nxt_s    = 1'b0;
        of_nxt_s    = 1'b0;
        if (flush) begin
            tp_nxt_s    = TP_ZERO;
            count_nxt_s = CNT_ZERO;
        end else begin
            case ({push, pop})
                2'b10: begin
                    wr_en_s  = 1'b1;
                    tp_nxt_s = tp_r + TP_ONE;
                    if (full_s) begin
                        of_nxt_s = 1'b1;
                    end else begin
                        count_nxt_s = count_r + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (empty_s) begin
                        uf_nxt_s = 1'b1;
                    end else begin
                        tp_nxt_s    = tp_r - TP_ONE;
                        count_nxt_s = count_r - CNT_ONE;
                    end
                end
                2'b11: begin
                    // A return immediately followed by a call replaces the top in place.
                    wr_en_s = 1'b1;
                    if (empty_s) begin
                        tp_nxt_s    = tp_r + TP_ONE;
                        count_nxt_s = CNT_ONE;
                    end else begin
                        wr_idx_s = top_idx_s;
                    end
                end
                default: begin
                    tp_nxt_s = tp_r;
                end
            endcase
        end
    end

    // Pointer, occupancy and event pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_r        <= TP_ZERO;
            count_r     <= CNT_ZERO;
            underflow_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            tp_r        <= tp_nxt_s;
            count_r     <= count_nxt_s;
            underflow_r <= uf_nxt_s;
            overflow_r  <= of_nxt_s;
        end
    end

    // Entry storage; flush leaves contents alone, only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 30'h0;
            end
        end else if (wr_en_s) begin
            mem_r[wr_idx_s] <= push_addr[31:2];
        end
    end

    assign top_addr  = empty_s ? 32'h0 : {mem_r[top_idx_s], 2'b00};
    assign top_valid = ~empty_s;
    assign full      = full_s;
    assign empty     = empty_s;
    assign underflow = underflow_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack: a reference model pushes expected outputs to a
// scoreboard queue as stimulus is driven; each scenario pops and compares after the clock edge.
module tb_return_addr_stack;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        push;
    logic [31:0] push_addr;
    logic        pop;
    logic [31:0] top_addr;
    logic        top_valid;
    logic        full;
    logic        empty;
    logic        underflow;
    logic        overflow;

    int n_checks;
    int n_fail;

    // Expected output vector: {top_addr, top_valid, full, empty, underflow, overflow}
    logic [36:0] sb_q [$];
    logic [29:0] m_mem [DEPTH];
    int          m_tp;
    int          m_cnt;

    return_addr_stack #(.DEPTH(4), .PTR_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .top_addr  (top_addr),
        .top_valid (top_valid),
        .full      (full),
        .empty     (empty),
        .underflow (underflow),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 30'h0;
        m_tp  = 0;
        m_cnt = 0;
        sb_q.delete();
    endtask

    // Reference model: computes the post-edge outputs for one cycle of stimulus.
    task automatic model_step(input logic f, input logic pu, input logic po, input logic [31:0] a);
        logic uf;
        logic of;
        logic [31:0] t;
        uf = 1'b0;
        of = 1'b0;
        if (f) begin
            m_cnt = 0;
            m_tp  = 0;
        end else if (pu && !po) begin
            m_mem[m_tp] = a[31:2];
            m_tp = (m_tp + 1) % DEPTH;
            if (m_cnt == DEPTH) of = 1'b1;
            else m_cnt = m_cnt + 1;
        end else if (!pu && po) begin
            if (m_cnt == 0) uf = 1'b1;
            else begin
                m_tp  = (m_tp + DEPTH - 1) % DEPTH;
                m_cnt = m_cnt - 1;
            end
        end else if (pu && po) begin
            if (m_cnt == 0) begin
                m_mem[m_tp] = a[31:2];
                m_tp  = (m_tp + 1) % DEPTH;
                m_cnt = 1;
            end else begin
                m_mem[(m_tp + DEPTH - 1) % DEPTH] = a[31:2];
            end
        end
        t = (m_cnt > 0) ? {m_mem[(m_tp + DEPTH - 1) % DEPTH], 2'b00} : 32'h0;
        sb_q.push_back({t, (m_cnt > 0), (m_cnt == DEPTH), (m_cnt == 0), uf, of});
    endtask

    task automatic drive(input logic f, input logic pu, input logic po, input logic [31:0] a);
        flush     = f;
        push      = pu;
        pop       = po;
        push_addr = a;
        model_step(f, pu, po, a);
        @(posedge clk);
        #1;
        flush = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    task automatic test_reset();
        logic [36:0] got;
        got = {top_addr, top_valid, full, empty, underflow, overflow};
        n_checks++;
        if (got !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", got, {32'h0, 5'b00100});
        end
    endtask

    task automatic test_basic();
        logic [34:0] seq  [5] = '{{3'b100, 32'h0}, {3'b010, 32'h1004}, {3'b010, 32'h2008},
                                  {3'b001, 32'h0}, {3'b001, 32'h0}};
        logic [31:0] want [5] = '{32'h0, 32'h1004, 32'h2008, 32'h1004, 32'h0};
        logic [36:0] got;
        logic [36:0] exp_v;
        for (int i = 0; i < 5; i++) begin
            drive(seq[i][34], seq[i][33], seq[i][32], seq[i][31:0]);
            got   = {top_addr, top_valid, full, empty, underflow, overflow};
            exp_v = sb_q.pop_front();
            n_checks += 2;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL basic step %0d: got %h want %h", i, got, exp_v);
            end
            if (top_addr !== want[i]) begin
                n_fail++;
                $display("FAIL basic top step %0d: got %h want %h", i, top_addr, want[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [34:0] seq  [11] = '{{3'b100, 32'h0}, {3'b010, 32'h10}, {3'b010, 32'h20},
                                   {3'b010, 32'h30}, {3'b010, 32'h40}, {3'b010, 32'h50},
                                   {3'b001, 32'h0}, {3'b001, 32'h0}, {3'b001, 32'h0},
                                   {3'b001, 32'h0}, {3'b001, 32'h0}};
        logic [31:0] want [11] = '{32'h0, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50,
                                   32'h40, 32'h30, 32'h20, 32'h0, 32'h0};
        logic [36:0] got;
        logic [36:0] exp_v;
        for (int i = 0; i < 11; i++) begin
            drive(seq[i][34], seq[i][33], seq[i][32], seq[i][31:0]);
            got   = {top_addr, top_valid, full, empty, underflow, overflow};
            exp_v = sb_q.pop_front();
            n_checks += 2;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL overflow step %0d: got %h want %h", i, got, exp_v);
            end
            if (top_addr !== want[i]) begin
                n_fail++;
                $display("FAIL overflow top step %0d: got %h want %h", i, top_addr, want[i]);
            end
        end
        n_checks++;
        if (underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow fifth pop underflow: got %b want 1", underflow);
        end
    endtask

    task automatic test_push_pop();
        logic [34:0] seq  [7] = '{{3'b100, 32'h0}, {3'b010, 32'h100}, {3'b011, 32'h200},
                                  {3'b001, 32'h0}, {3'b011, 32'h300}, {3'b100, 32'h0},
                                  {3'b010, 32'h1007}};
        logic [31:0] want [7] = '{32'h0, 32'h100, 32'h200, 32'h0, 32'h300, 32'h0, 32'h1004};
        logic [36:0] got;
        logic [36:0] exp_v;
        for (int i = 0; i < 7; i++) begin
            drive(seq[i][34], seq[i][33], seq[i][32], seq[i][31:0]);
            got   = {top_addr, top_valid, full, empty, underflow, overflow};
            exp_v = sb_q.pop_front();
            n_checks += 2;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL push_pop step %0d: got %h want %h", i, got, exp_v);
            end
            if (top_addr !== want[i]) begin
                n_fail++;
                $display("FAIL push_pop top step %0d: got %h want %h", i, top_addr, want[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [34:0] seq  [6] = '{{3'b100, 32'h0}, {3'b010, 32'h11}, {3'b010, 32'h22},
                                  {3'b010, 32'h33}, {3'b110, 32'h999}, {3'b010, 32'h44}};
        logic [31:0] want [6] = '{32'h0, 32'h10, 32'h20, 32'h30, 32'h0, 32'h44};
        logic [36:0] got;
        logic [36:0] exp_v;
        for (int i = 0; i < 6; i++) begin
            drive(seq[i][34], seq[i][33], seq[i][32], seq[i][31:0]);
            got   = {top_addr, top_valid, full, empty, underflow, overflow};
            exp_v = sb_q.pop_front();
            n_checks += 2;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL flush step %0d: got %h want %h", i, got, exp_v);
            end
            if (top_addr !== want[i]) begin
                n_fail++;
                $display("FAIL flush top step %0d: got %h want %h", i, top_addr, want[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [36:0] got;
        logic [36:0] exp_v;
        drive(1'b0, 1'b1, 1'b0, 32'hA0);
        drive(1'b0, 1'b1, 1'b0, 32'hB0);
        exp_v = sb_q.pop_front();
        exp_v = sb_q.pop_front();
        got   = {top_addr, top_valid, full, empty, underflow, overflow};
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL async pre-reset: got %h want %h", got, exp_v);
        end
        #3;
        rst_n = 1'b0;
        #1;
        got = {top_addr, top_valid, full, empty, underflow, overflow};
        n_checks++;
        if (got !== {32'h0, 5'b00100}) begin
            n_fail++;
            $display("FAIL async reset mid-cycle: got %h want %h", got, {32'h0, 5'b00100});
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        got   = {top_addr, top_valid, full, empty, underflow, overflow};
        exp_v = sb_q.pop_front();
        n_checks += 2;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL async post-release pop: got %h want %h", got, exp_v);
        end
        if (underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL async underflow: got %b want 1", underflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [36:0] got;
        logic [36:0] exp_v;
        logic [31:0] a;
        logic f;
        for (int i = 0; i < 60; i++) begin
            f = ($urandom_range(0, 11) == 0);
            a = $urandom;
            drive(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
            got   = {top_addr, top_valid, full, empty, underflow, overflow};
            exp_v = sb_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %h want %h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_addr = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_overflow();
        test_push_pop();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware return-address stack for the single-cycle RISC fetch path. It is the consumer of the link address (PC+4) that the PC adder produces.
- On a call (JAL/JALR with rd=x1/x5), the link address is pushed. On a return (JALR rs1=x1/x5, rd=x0), the stored address is popped and offered to the next-PC mux as the predicted target.
- Circular storage with a saturating occupancy count; the oldest entry is overwritten on overflow.

Parameters:
DEPTH, 4, number of stored return addresses; power of two, 2..16
PTR_W, 2, log2(DEPTH); must equal clog2(DEPTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all entries (pipeline redirect / trap)
push  input  1  write push_addr as new top this cycle
push_addr  input  32  link address (PC+4); bits [1:0] ignored
pop  input  1  remove current top this cycle
top_addr  output  32  current top entry, bits [1:0] always 0
top_valid  output  1  1 when count > 0
full  output  1  1 when count == DEPTH
empty  output  1  1 when count == 0
underflow  output  1  registered one-cycle pulse: pop with empty and no push
overflow  output  1  registered one-cycle pulse: push (without pop) while full

Behaviour:
- Reset (rst_n low, asynchronous): all storage entries, the top pointer (tp) and count go to 0, so top_addr=0, top_valid=0, empty=1, full=0, underflow=0, overflow=0. Release is synchronous to the next clk edge.
- Storage holds addr[31:2] (30 bits per entry). top_addr = {mem[tp-1 mod DEPTH], 2'b00} when count>0, else 32'h0. top_addr is combinational from registers and reflects an update the cycle after it.
- Priority per clock edge: flush > (push,pop) decode.
- flush=1: count←0, tp←0, storage untouched, pulses←0. Push/pop are ignored that cycle.
- push=1, pop=0:
  - Write mem[tp]←push_addr[31:2] and tp←tp+1 (mod DEPTH).
  - count←min(count+1, DEPTH).
  - If count==DEPTH beforehand, the oldest entry is overwritten and overflow=1 next cycle.
- push=0, pop=1:
  - If count>0: tp←tp-1 (mod DEPTH), count←count-1.
  - If count==0: no state change, underflow=1 next cycle.
- push=1, pop=1 (return followed immediately by a call, e.g. tail call):
  - If count>0: mem[tp-1]←push_addr[31:2]; tp and count are unchanged.
  - If count==0: behaves as a push only (count←1). No underflow and no overflow.
- push=0, pop=0: hold.
- underflow/overflow are high for exactly one cycle per offending event. They are not sticky.
- Wrap-around: tp wraps DEPTH-1→0 on push and 0→DEPTH-1 on pop. After overflow, count stays DEPTH and the most recent DEPTH addresses are retained.
- Popping after overflow returns entries newest-first. The (DEPTH+1)-th pop underflows even though stale data exists.
- Asynchronous reset mid-sequence discards all content immediately, independent of clk.
- No internal combinational path from push/pop to top_addr; all outputs derive from registers.

Test Plan:
- Reset, then push 0x0000_1004, 0x0000_2008 on consecutive cycles → top_addr=0x0000_2008, count=2, empty=0; pop → top_addr=0x0000_1004; pop → empty=1, top_addr=0, top_valid=0.
- DEPTH=4: push 0x10,0x20,0x30,0x40 → full=1; push 0x50 → overflow pulses one cycle, full stays 1; four pops return 0x50,0x40,0x30,0x20; fifth pop → underflow pulse, state unchanged.
- Push 0x100 then push+pop together with 0x200 → top_addr=0x200, count still 1; push+pop with empty stack and 0x300 → top_addr=0x300, count=1, no pulses.
- Push 0x0000_1007 → top_addr=0x0000_1004 (low bits dropped).
- Push three entries, assert flush together with push 0x999 → empty=1 next cycle, top_addr=0; subsequent push 0x44 → top_addr=0x44, count=1.
- Push two entries, drop rst_n between clk edges → outputs reach reset values without a clock edge; after release, a pop gives underflow=1.
